// File: rtl/sprite_arb_pkg.sv
// sprite_arb_pkg
//   Shared types and default sizing for the sprite RAM arbiter.
//   arb_state_t : write-commit FSM states (IMMED, HOLD, COMMIT)
//   wr_entry_t  : one pending write {addr, data} at the default widths
package sprite_arb_pkg;

  localparam int ADDR_W_DEF     = 5;
  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IMMED  = 2'd0,
    HOLD   = 2'd1,
    COMMIT = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/sprite_arb_fifo.sv
// sprite_arb_fifo
//   Synchronous FIFO holding pending RAM writes.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset (pointers/flags only)
//     push/wdata: enqueue (ignored when full)
//     pop/head  : dequeue; head is the oldest entry (valid when !empty)
//     empty     : registered empty flag
//     ready     : registered !full; held 0 during reset, rises the cycle after
//     count     : registered occupancy
module sprite_arb_fifo #(
  parameter int WIDTH      = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [WIDTH-1:0]                  wdata,
  input  logic                              pop,
  output logic [WIDTH-1:0]                  head,
  output logic                              empty,
  output logic                              ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [WIDTH-1:0] store [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full;
  logic             push_ok, pop_ok;
  logic [CW-1:0]    count_nxt;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = store[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)
      count_nxt = count + CW'(1);
    else if (pop_ok && !push_ok)
      count_nxt = count - CW'(1);
  end

  // Control: pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ready  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(FIFO_DEPTH));
      empty <= (count_nxt == '0);
      ready <= (count_nxt != CW'(FIFO_DEPTH));
    end
  end

  // Data storage carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sprite_mem_arbiter.sv
// sprite_mem_arbiter
//   Arbitrates a single-port sprite/config RAM between display reads (hard
//   priority, never stalled) and buffered SPI writes. Writes drain either
//   immediately (sync_mode=0) or as a frame-start snapshot (sync_mode=1).
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     sync_mode, frame_start   : commit mode, start-of-frame pulse
//     wr_valid/wr_ready/wr_addr/wr_data : write request channel
//     rd_req/rd_addr           : display read request
//     rd_valid/rd_data         : read return, one cycle after rd_req
//     mem_we/mem_addr/mem_wdata/mem_rdata : RAM port (1-cycle read latency)
//     pending                  : write FIFO occupancy
//     stall_cnt                : saturating count of writes blocked by reads
//   Build option: define SPRITE_ARB_STATS_EN to enable stall_cnt; otherwise
//   it is tied to zero.
module sprite_mem_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sync_mode,
  input  logic                              frame_start,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [DATA_W-1:0]                 wr_data,
  input  logic                              rd_req,
  input  logic [ADDR_W-1:0]                 rd_addr,
  output logic                              rd_valid,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   pending,
  output logic [7:0]                        stall_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  arb_state_t                 state;
  logic [CNT_W-1:0]           commit_left;
  logic                       drain_en, push, pop, fifo_empty;
  logic [ADDR_W+DATA_W-1:0]   head;
  logic [ADDR_W-1:0]          head_addr;
  logic [DATA_W-1:0]          head_data;
  logic                       vld_p1;

  assign push     = wr_valid && wr_ready;
  assign drain_en = (state != HOLD);
  // Reads own the port; reset blocks any write in flight.
  assign pop      = drain_en && !fifo_empty && !rd_req && !rst;
  assign {head_addr, head_data} = head;

  sprite_arb_fifo #(
    .WIDTH      (ADDR_W + DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({wr_addr, wr_data}),
    .pop   (pop),
    .head  (head),
    .empty (fifo_empty),
    .ready (wr_ready),
    .count (pending)
  );

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (rd_req) begin
        mem_addr = rd_addr;
      end else if (pop) begin
        mem_we    = 1'b1;
        mem_addr  = head_addr;
        mem_wdata = head_data;
      end
    end
  end

  // commit_left snapshots the occupancy at frame start so writes arriving
  // during COMMIT are left for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IMMED;
      commit_left <= '0;
    end else begin
      case (state)
        IMMED: if (sync_mode) state <= HOLD;
        HOLD: begin
          if (!sync_mode) begin
            state <= IMMED;
          end else if (frame_start && (pending != '0)) begin
            state       <= COMMIT;
            commit_left <= pending;
          end
        end
        COMMIT: begin
          if (pop) begin
            commit_left <= commit_left - CNT_W'(1);
            if (commit_left == CNT_W'(1))
              state <= sync_mode ? HOLD : IMMED;
          end
        end
        default: state <= IMMED;
      endcase
    end
  end

  // ---- stage p0 -> p1: RAM read latency ----
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= rd_req;
  end

  assign rd_valid = vld_p1;
  assign rd_data  = vld_p1 ? mem_rdata : '0;

`ifdef SPRITE_ARB_STATS_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic stall;
  assign stall = drain_en && !fifo_empty && rd_req;

  always_ff @(posedge clk) begin
    if (rst)        stall_cnt <= 8'd0;
    else if (stall) stall_cnt <= sat_inc8(stall_cnt);
  end
`else
  assign stall_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
module tb_sprite_mem_arbiter;

`ifdef SPRITE_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk;
  logic       rst, sync_mode, frame_start, wr_valid, rd_req;
  logic       wr_ready, rd_valid, mem_we;
  logic [4:0] wr_addr, rd_addr, mem_addr;
  logic [7:0] wr_data, rd_data, mem_wdata, mem_rdata;
  logic [2:0] pending;
  logic [7:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  sprite_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .sync_mode   (sync_mode),
    .frame_start (frame_start),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .pending     (pending),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM environment with one-cycle read latency.
  logic [7:0] ram [32];
  logic       ram_clr;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int k = 0; k < 32; k++) ram[k] <= 8'h00;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic       rst, wv, rr;
    logic [4:0] wa, ra;
    logic [7:0] wd;
    logic       e_wr_ready, e_rd_valid, e_we;
    logic [7:0] e_rd_data, e_wdata;
    logic [4:0] e_addr;
    logic [2:0] e_pending;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t v(input logic r, input logic wv, input logic [4:0] wa,
                             input logic [7:0] wd, input logic rr, input logic [4:0] ra,
                             input logic ewr, input logic erv, input logic [7:0] erd,
                             input logic ewe, input logic [4:0] ea, input logic [7:0] ewd,
                             input logic [2:0] ep);
    vec_t t;
    t.rst = r; t.wv = wv; t.wa = wa; t.wd = wd; t.rr = rr; t.ra = ra;
    t.e_wr_ready = ewr; t.e_rd_valid = erv; t.e_rd_data = erd;
    t.e_we = ewe; t.e_addr = ea; t.e_wdata = ewd; t.e_pending = ep;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Move to the next drive point and drop all pulse-style inputs.
  task automatic next_cycle();
    @(negedge clk);
    rst = 1'b0; frame_start = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
  endtask

  task automatic push(input logic [4:0] a, input logic [7:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic do_reset();
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b1;
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; sync_mode = 1'b0; frame_start = 1'b0; wr_valid = 1'b0;
    rd_req = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; ram_clr = 1'b1;
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b1; ram_clr = 1'b0;

    // Immediate commit, read priority, ordering, no forwarding.
    vecs[0]  = v(1, 0, 0,     0,     0, 0,     0, 0, 8'h00, 0, 0,     0,     0);
    vecs[1]  = v(0, 0, 0,     0,     0, 0,     0, 0, 8'h00, 0, 0,     0,     0);
    vecs[2]  = v(0, 1, 5'h03, 8'hA5, 0, 0,     1, 0, 8'h00, 0, 0,     0,     0);
    vecs[3]  = v(0, 0, 0,     0,     0, 0,     1, 0, 8'h00, 1, 5'h03, 8'hA5, 1);
    vecs[4]  = v(0, 0, 0,     0,     1, 5'h03, 1, 0, 8'h00, 0, 5'h03, 0,     0);
    vecs[5]  = v(0, 0, 0,     0,     0, 0,     1, 1, 8'hA5, 0, 0,     0,     0);
    vecs[6]  = v(0, 1, 5'h10, 8'h11, 1, 5'h05, 1, 0, 8'h00, 0, 5'h05, 0,     0);
    vecs[7]  = v(0, 1, 5'h11, 8'h22, 1, 5'h05, 1, 1, 8'h00, 0, 5'h05, 0,     1);
    vecs[8]  = v(0, 0, 0,     0,     1, 5'h10, 1, 1, 8'h00, 0, 5'h10, 0,     2);
    vecs[9]  = v(0, 0, 0,     0,     1, 5'h03, 1, 1, 8'h00, 0, 5'h03, 0,     2);
    for (int i = 10; i < 16; i++)
      vecs[i] = v(0, 0, 0,    0,     1, 5'h03, 1, 1, 8'hA5, 0, 5'h03, 0,     2);
    vecs[16] = v(0, 0, 0,     0,     0, 0,     1, 1, 8'hA5, 1, 5'h10, 8'h11, 2);
    vecs[17] = v(0, 0, 0,     0,     0, 0,     1, 0, 8'h00, 1, 5'h11, 8'h22, 1);
    vecs[18] = v(0, 0, 0,     0,     1, 5'h10, 1, 0, 8'h00, 0, 5'h10, 0,     0);
    vecs[19] = v(0, 0, 0,     0,     0, 0,     1, 1, 8'h11, 0, 0,     0,     0);

    for (int i = 0; i < 20; i++) begin
      next_cycle();
      rst = vecs[i].rst; wr_valid = vecs[i].wv; wr_addr = vecs[i].wa;
      wr_data = vecs[i].wd; rd_req = vecs[i].rr; rd_addr = vecs[i].ra;
      #1;
      check($sformatf("v%0d wr_ready", i), wr_ready, vecs[i].e_wr_ready);
      check($sformatf("v%0d rd_valid", i), rd_valid, vecs[i].e_rd_valid);
      check($sformatf("v%0d rd_data", i), rd_data, vecs[i].e_rd_data);
      check($sformatf("v%0d mem_we", i), mem_we, vecs[i].e_we);
      check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d pending", i), pending, vecs[i].e_pending);
    end

    // Frame-synced commit; a mid-COMMIT write waits for the next frame.
    sync_mode = 1'b1;
    do_reset();
    next_cycle(); push(5'h01, 8'h31); #1; check("fs c1 we", mem_we, 0);
    next_cycle(); push(5'h02, 8'h32); #1; check("fs c2 we", mem_we, 0);
    next_cycle(); push(5'h04, 8'h34); #1; check("fs c3 we", mem_we, 0);
    next_cycle(); #1; check("fs c4 pending", pending, 3); check("fs c4 we", mem_we, 0);
    next_cycle(); #1; check("fs c5 we", mem_we, 0);
    next_cycle(); frame_start = 1'b1; #1; check("fs c6 we", mem_we, 0);
    next_cycle(); push(5'h07, 8'h37); #1;
    check("fs c7 we", mem_we, 1); check("fs c7 addr", mem_addr, 5'h01);
    check("fs c7 data", mem_wdata, 8'h31);
    next_cycle(); #1; check("fs c8 addr", mem_addr, 5'h02); check("fs c8 pending", pending, 3);
    next_cycle(); #1; check("fs c9 we", mem_we, 1); check("fs c9 addr", mem_addr, 5'h04);
    next_cycle(); #1; check("fs c10 we", mem_we, 0); check("fs c10 pending", pending, 1);
    next_cycle(); #1; check("fs c11 we", mem_we, 0);
    next_cycle(); frame_start = 1'b1; #1; check("fs c12 we", mem_we, 0);
    next_cycle(); #1; check("fs c13 we", mem_we, 1); check("fs c13 addr", mem_addr, 5'h07);
    check("fs c13 data", mem_wdata, 8'h37);
    next_cycle(); rd_req = 1'b1; rd_addr = 5'h04; #1;
    check("fs c14 we", mem_we, 0); check("fs c14 pending", pending, 0);
    next_cycle(); #1; check("fs c15 rd_data", rd_data, 8'h34);

    // FIFO full in HOLD, then drain after switching to immediate mode.
    sync_mode = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      push(5'(8 + ((i < 4) ? i : 4)), 8'(8'h48 + ((i < 4) ? i : 4)));
      if (i == 5) sync_mode = 1'b0;
      #1;
      check($sformatf("full c%0d ready", i + 1), wr_ready, (i < 4) ? 1 : 0);
      check($sformatf("full c%0d pending", i + 1), pending, (i < 4) ? i : 4);
      check($sformatf("full c%0d we", i + 1), mem_we, 0);
    end
    next_cycle(); push(5'h0C, 8'h4C); #1;
    check("full c7 ready", wr_ready, 0); check("full c7 addr", mem_addr, 5'h08);
    check("full c7 we", mem_we, 1); check("full c7 pending", pending, 4);
    next_cycle(); push(5'h0C, 8'h4C); #1;
    check("full c8 ready", wr_ready, 1); check("full c8 addr", mem_addr, 5'h09);
    check("full c8 pending", pending, 3);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      check($sformatf("full c%0d addr", i + 9), mem_addr, 10 + i);
      check($sformatf("full c%0d data", i + 9), mem_wdata, 8'h4A + i);
      check($sformatf("full c%0d pending", i + 9), pending, 3 - i);
    end
    next_cycle(); #1; check("full c12 we", mem_we, 0); check("full c12 pending", pending, 0);

    // Reset in the middle of a COMMIT burst.
    sync_mode = 1'b1;
    do_reset();
    next_cycle(); push(5'd20, 8'h50);
    next_cycle(); push(5'd21, 8'h51);
    next_cycle(); push(5'd22, 8'h52);
    next_cycle(); frame_start = 1'b1; #1; check("rc c4 pending", pending, 3);
    next_cycle(); rst = 1'b1; sync_mode = 1'b0; #1;
    check("rc c5 we", mem_we, 0); check("rc c5 pending", pending, 3);
    next_cycle(); rd_req = 1'b1; rd_addr = 5'd20; #1;
    check("rc c6 pending", pending, 0); check("rc c6 ready", wr_ready, 0);
    check("rc c6 rd_valid", rd_valid, 0); check("rc c6 stall", stall_cnt, 0);
    next_cycle(); push(5'd23, 8'h53); #1;
    check("rc c7 rd_valid", rd_valid, 1); check("rc c7 rd_data", rd_data, 8'h00);
    check("rc c7 ready", wr_ready, 1);
    next_cycle(); #1;
    check("rc c8 we", mem_we, 1); check("rc c8 addr", mem_addr, 5'd23);
    check("rc c8 data", mem_wdata, 8'h53);

    // Stall counter under a long read burst.
    sync_mode = 1'b0;
    do_reset();
    next_cycle(); rd_req = 1'b1; push(5'd25, 8'h66); #1; check("st c1 cnt", stall_cnt, 0);
    for (int i = 0; i < 10; i++) begin
      next_cycle(); rd_req = 1'b1;
    end
    next_cycle(); rd_req = 1'b1; #1;
    check("st c12 cnt", stall_cnt, STATS ? 10 : 0); check("st c12 we", mem_we, 0);
    for (int i = 0; i < 300; i++) begin
      next_cycle(); rd_req = 1'b1;
    end
    next_cycle(); rd_req = 1'b1; #1;
    check("st sat cnt", stall_cnt, STATS ? 255 : 0); check("st sat pending", pending, 1);
    next_cycle(); #1;
    check("st drain we", mem_we, 1); check("st drain addr", mem_addr, 5'd25);
    check("st hold cnt", stall_cnt, STATS ? 255 : 0);
    do_reset();
    #1; check("st reset cnt", stall_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
